// File: rtl/hazard_control_unit_if.sv
// Purpose: bundles the hazard unit's pipeline-side inputs and control outputs into one port.
// Ports  : ID/EX operand and opcode info, branch and memory status in; enables, flushes,
//          sticky memory error flag and performance counters out.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_ADDR1;
    logic [4:0]       ID_ADDR2;
    logic [6:0]       ID_OPCODE;
    logic [4:0]       EXE_ADDR;
    logic             EXE_MEMREAD;
    logic             BJ_TAKEN;
    logic             MEM_REQ;
    logic             MEM_READY;

    logic             PC_EN;
    logic             IFID_EN;
    logic             IDEX_EN;
    logic             EXMEM_EN;
    logic             IFID_FLUSH;
    logic             IDEX_FLUSH;
    logic             MEMWB_FLUSH;
    logic             MEM_ERR;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    // Pipeline side: drives hazard information, consumes control.
    modport master (
        output ID_ADDR1, ID_ADDR2, ID_OPCODE, EXE_ADDR, EXE_MEMREAD,
               BJ_TAKEN, MEM_REQ, MEM_READY,
        input  PC_EN, IFID_EN, IDEX_EN, EXMEM_EN,
               IFID_FLUSH, IDEX_FLUSH, MEMWB_FLUSH,
               MEM_ERR, STALL_CNT, FLUSH_CNT
    );

    // Hazard unit side.
    modport slave (
        input  ID_ADDR1, ID_ADDR2, ID_OPCODE, EXE_ADDR, EXE_MEMREAD,
               BJ_TAKEN, MEM_REQ, MEM_READY,
        output PC_EN, IFID_EN, IDEX_EN, EXMEM_EN,
               IFID_FLUSH, IDEX_FLUSH, MEMWB_FLUSH,
               MEM_ERR, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Purpose: stall/flush controller for the 5-stage RV32I pipeline (load-use, taken branch,
//          data-memory wait, memory timeout halt) with saturating stall/flush counters.
// Latency: enables/flushes are combinational from state + inputs; state and counters update on CLK.
// Ports  : CLK, RESET (sync, active-high), hcu (slave modport of hazard_control_unit_if).
module hazard_control_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    hazard_control_unit_if.slave  hcu
);

    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Last WAIT_CNT value tolerated before the timeout halt.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctl_t;

    //                                         pc ifid idex exmem | fl_ifid fl_idex fl_memwb
    localparam ctl_t CTL_NORMAL = ctl_t'(7'b1_1_1_1_0_0_0);
    localparam ctl_t CTL_BRANCH = ctl_t'(7'b1_1_1_1_1_1_0);
    localparam ctl_t CTL_LOADUSE= ctl_t'(7'b0_0_1_1_0_1_0);
    localparam ctl_t CTL_FREEZE = ctl_t'(7'b0_0_0_0_0_0_1);
    localparam ctl_t CTL_HALT   = ctl_t'(7'b0_0_0_0_0_0_0);
    localparam ctl_t CTL_RESET  = ctl_t'(7'b0_0_0_0_1_1_1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_lu;
    logic             w_freeze;
    ctl_t             w_run_ctl;
    ctl_t             w_ctl;

    // Which ID operands are actually read, decided by opcode alone.
    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (hcu.ID_OPCODE)
            OP_JALR, OP_LOAD, OP_ITYPE: w_rs1_used = 1'b1;
            OP_STORE, OP_RTYPE, OP_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_lu = hcu.EXE_MEMREAD && (hcu.EXE_ADDR != 5'd0) &&
                  ((w_rs1_used && (hcu.EXE_ADDR == hcu.ID_ADDR1)) ||
                   (w_rs2_used && (hcu.EXE_ADDR == hcu.ID_ADDR2)));

    assign w_freeze = hcu.MEM_REQ && !hcu.MEM_READY;

    // Non-freeze decision: a taken branch squashes the dependent instruction anyway,
    // so it outranks the load-use bubble.
    always_comb begin
        w_run_ctl = CTL_NORMAL;
        if (hcu.BJ_TAKEN) begin
            w_run_ctl = CTL_BRANCH;
        end else if (w_lu) begin
            w_run_ctl = CTL_LOADUSE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_ctl          = CTL_NORMAL;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        if (RESET) begin
            w_ctl = CTL_RESET;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        w_ctl          = CTL_FREEZE;
                        w_state_nxt    = ST_MEM_WAIT;
                        w_wait_cnt_nxt = 8'd1;
                    end else begin
                        w_ctl = w_run_ctl;
                    end
                end
                ST_MEM_WAIT: begin
                    if (hcu.MEM_READY) begin
                        // Release cycle: the held pipeline advances, including any branch in EX.
                        w_ctl          = w_run_ctl;
                        w_state_nxt    = ST_RUN;
                        w_wait_cnt_nxt = 8'd0;
                    end else begin
                        w_ctl = CTL_FREEZE;
                        if (r_wait_cnt == LP_WAIT_LAST) begin
                            w_mem_err_nxt = 1'b1;
                            w_state_nxt   = ST_HALT;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                        end
                    end
                end
                ST_HALT: begin
                    w_ctl = CTL_HALT;
                end
                default: begin
                    w_ctl       = CTL_HALT;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Outside reset, IFID_FLUSH is only ever raised by a serviced taken branch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != ST_HALT) && !w_ctl.pc_en && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ctl.ifid_flush && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hcu.PC_EN       = w_ctl.pc_en;
    assign hcu.IFID_EN     = w_ctl.ifid_en;
    assign hcu.IDEX_EN     = w_ctl.idex_en;
    assign hcu.EXMEM_EN    = w_ctl.exmem_en;
    assign hcu.IFID_FLUSH  = w_ctl.ifid_flush;
    assign hcu.IDEX_FLUSH  = w_ctl.idex_flush;
    assign hcu.MEMWB_FLUSH = w_ctl.memwb_flush;
    assign hcu.MEM_ERR     = r_mem_err;
    assign hcu.STALL_CNT   = r_stall_cnt;
    assign hcu.FLUSH_CNT   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: directed self-checking bench for hazard_control_unit (two instances: default-size
//          counters/timeout and a CNT_W=4, MEM_TIMEOUT=4 instance sharing the same stimulus).
// Ports  : none; clock generated locally, outputs sampled 1 time unit away from CLK edges.
module tb_hazard_control_unit;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    logic CLK;
    logic RESET;

    logic [4:0] id_addr1;
    logic [4:0] id_addr2;
    logic [6:0] id_opcode;
    logic [4:0] exe_addr;
    logic       exe_memread;
    logic       bj_taken;
    logic       mem_req;
    logic       mem_ready;

    int n_checks;
    int n_fail;

    hazard_control_unit_if #(.CNT_W(16)) bus_a ();
    hazard_control_unit_if #(.CNT_W(4))  bus_b ();

    assign bus_a.ID_ADDR1    = id_addr1;
    assign bus_a.ID_ADDR2    = id_addr2;
    assign bus_a.ID_OPCODE   = id_opcode;
    assign bus_a.EXE_ADDR    = exe_addr;
    assign bus_a.EXE_MEMREAD = exe_memread;
    assign bus_a.BJ_TAKEN    = bj_taken;
    assign bus_a.MEM_REQ     = mem_req;
    assign bus_a.MEM_READY   = mem_ready;

    assign bus_b.ID_ADDR1    = id_addr1;
    assign bus_b.ID_ADDR2    = id_addr2;
    assign bus_b.ID_OPCODE   = id_opcode;
    assign bus_b.EXE_ADDR    = exe_addr;
    assign bus_b.EXE_MEMREAD = exe_memread;
    assign bus_b.BJ_TAKEN    = bj_taken;
    assign bus_b.MEM_REQ     = mem_req;
    assign bus_b.MEM_READY   = mem_ready;

    hazard_control_unit #(.CNT_W(16), .MEM_TIMEOUT(64)) u_dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .hcu   (bus_a)
    );

    hazard_control_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) u_dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .hcu   (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        id_addr1    = 5'd0;
        id_addr2    = 5'd0;
        id_opcode   = OP_NOP;
        exe_addr    = 5'd0;
        exe_memread = 1'b0;
        bj_taken    = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        RESET = 1'b1;
        #1;
        chk("rst_pc_en",       32'(bus_a.PC_EN),       32'd0);
        chk("rst_ifid_en",     32'(bus_a.IFID_EN),     32'd0);
        chk("rst_ifid_flush",  32'(bus_a.IFID_FLUSH),  32'd1);
        chk("rst_idex_flush",  32'(bus_a.IDEX_FLUSH),  32'd1);
        chk("rst_memwb_flush", 32'(bus_a.MEMWB_FLUSH), 32'd1);
        tick();
        RESET = 1'b0;
        #1;
        chk("post_rst_stall",  32'(bus_a.STALL_CNT),   32'd0);
        chk("post_rst_flush",  32'(bus_a.FLUSH_CNT),   32'd0);
        chk("post_rst_err",    32'(bus_a.MEM_ERR),     32'd0);
        chk("idle_pc_en",      32'(bus_a.PC_EN),       32'd1);
        chk("idle_memwb_fl",   32'(bus_a.MEMWB_FLUSH), 32'd0);

        // Load x5 in EX, add x6,x5,x1 in ID: exactly one bubble.
        exe_memread = 1'b1; exe_addr = 5'd5;
        id_opcode = OP_RTYPE; id_addr1 = 5'd5; id_addr2 = 5'd1;
        #1;
        chk("lu_pc_en",      32'(bus_a.PC_EN),      32'd0);
        chk("lu_ifid_en",    32'(bus_a.IFID_EN),    32'd0);
        chk("lu_idex_flush", 32'(bus_a.IDEX_FLUSH), 32'd1);
        chk("lu_exmem_en",   32'(bus_a.EXMEM_EN),   32'd1);
        tick();
        exe_memread = 1'b0; exe_addr = 5'd0;   // bubble now in EX
        #1;
        chk("lu_after_pc_en",  32'(bus_a.PC_EN),      32'd1);
        chk("lu_after_idex_fl",32'(bus_a.IDEX_FLUSH), 32'd0);
        chk("lu_stall_cnt",    32'(bus_a.STALL_CNT),  32'd1);

        // Load x0 feeding add x6,x0,x0: no stall.
        exe_memread = 1'b1; exe_addr = 5'd0;
        id_opcode = OP_RTYPE; id_addr1 = 5'd0; id_addr2 = 5'd0;
        #1;
        chk("x0_pc_en", 32'(bus_a.PC_EN), 32'd1);
        tick();
        // JAL reads no registers even if its rs1 field bits match.
        exe_addr = 5'd5; id_opcode = OP_JAL; id_addr1 = 5'd5; id_addr2 = 5'd5;
        #1;
        chk("jal_pc_en", 32'(bus_a.PC_EN), 32'd1);
        tick();
        // I-type ignores its rs2 field.
        id_opcode = OP_ITYPE; id_addr1 = 5'd1; id_addr2 = 5'd5;
        #1;
        chk("itype_rs2_pc_en", 32'(bus_a.PC_EN), 32'd1);
        tick();
        chk("no_stall_cnt", 32'(bus_a.STALL_CNT), 32'd1);
        // Store uses rs2: stall.
        id_opcode = OP_STORE; id_addr1 = 5'd1; id_addr2 = 5'd5;
        #1;
        chk("store_rs2_pc_en", 32'(bus_a.PC_EN), 32'd0);
        tick();
        chk("store_stall_cnt", 32'(bus_a.STALL_CNT), 32'd2);

        // Taken branch together with a load-use: the branch wins.
        pulse_reset();
        exe_memread = 1'b1; exe_addr = 5'd5;
        id_opcode = OP_RTYPE; id_addr1 = 5'd5; id_addr2 = 5'd1;
        bj_taken = 1'b1;
        #1;
        chk("bj_lu_ifid_fl", 32'(bus_a.IFID_FLUSH), 32'd1);
        chk("bj_lu_idex_fl", 32'(bus_a.IDEX_FLUSH), 32'd1);
        chk("bj_lu_pc_en",   32'(bus_a.PC_EN),      32'd1);
        tick();
        idle_inputs();
        #1;
        chk("bj_flush_cnt", 32'(bus_a.FLUSH_CNT), 32'd1);
        chk("bj_stall_cnt", 32'(bus_a.STALL_CNT), 32'd0);

        // Three-cycle memory wait with a taken branch held in EX.
        pulse_reset();
        mem_req = 1'b1; mem_ready = 1'b0; bj_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_pc_en",    32'(bus_a.PC_EN),       32'd0);
            chk("frz_exmem_en", 32'(bus_a.EXMEM_EN),    32'd0);
            chk("frz_memwb_fl", 32'(bus_a.MEMWB_FLUSH), 32'd1);
            chk("frz_ifid_fl",  32'(bus_a.IFID_FLUSH),  32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("rel_ifid_fl",  32'(bus_a.IFID_FLUSH),  32'd1);
        chk("rel_idex_fl",  32'(bus_a.IDEX_FLUSH),  32'd1);
        chk("rel_pc_en",    32'(bus_a.PC_EN),       32'd1);
        chk("rel_memwb_fl", 32'(bus_a.MEMWB_FLUSH), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("wait_stall_cnt", 32'(bus_a.STALL_CNT), 32'd3);
        chk("wait_flush_cnt", 32'(bus_a.FLUSH_CNT), 32'd1);
        chk("wait_b_no_err",  32'(bus_b.MEM_ERR),   32'd0);
        chk("wait_b_stall",   32'(bus_b.STALL_CNT), 32'd3);

        // Memory timeout on the MEM_TIMEOUT=4 instance.
        pulse_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_early", 32'(bus_b.MEM_ERR), 32'd0);
        tick();
        chk("to_err_set",     32'(bus_b.MEM_ERR),     32'd1);
        chk("to_halt_pc_en",  32'(bus_b.PC_EN),       32'd0);
        chk("to_halt_memwb",  32'(bus_b.MEMWB_FLUSH), 32'd0);
        chk("to_a_still_frz", 32'(bus_a.MEMWB_FLUSH), 32'd1);
        chk("to_b_stall",     32'(bus_b.STALL_CNT),   32'd4);
        mem_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk("halt_hold_pc_en",  32'(bus_b.PC_EN),   32'd0);
        chk("halt_hold_ifid_en",32'(bus_b.IFID_EN), 32'd0);
        chk("a_release_pc_en",  32'(bus_a.PC_EN),   32'd1);
        tick();
        chk("halt_stall_frozen", 32'(bus_b.STALL_CNT), 32'd4);
        chk("halt_err_sticky",   32'(bus_b.MEM_ERR),   32'd1);
        pulse_reset();
        #1;
        chk("halt_rst_err",   32'(bus_b.MEM_ERR),   32'd0);
        chk("halt_rst_stall", 32'(bus_b.STALL_CNT), 32'd0);
        chk("halt_rst_pc_en", 32'(bus_b.PC_EN),     32'd1);

        // Twenty consecutive load-use stalls: 4-bit counter saturates.
        exe_memread = 1'b1; exe_addr = 5'd7;
        id_opcode = OP_RTYPE; id_addr1 = 5'd2; id_addr2 = 5'd7;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_b_stall", 32'(bus_b.STALL_CNT), 32'd15);
        chk("sat_a_stall", 32'(bus_a.STALL_CNT), 32'd20);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
